// File: rtl/poly_horner_pkg.sv
// Shared types, limits and the saturation helper for the Horner polynomial evaluator.
package poly_horner_pkg;

  localparam int C_MAX_ORDER = 15;
  localparam int C_ADDR_W    = 4;
  // Working width of the clamp helper; wide enough for any legal product plus carry.
  localparam int C_SAT_W     = 128;

  typedef enum logic [1:0] {
    SM_IDLE   = 2'd0,
    SM_MAC    = 2'd1,
    SM_OUTPUT = 2'd2
  } state_t;

  // Clamp a sign-extended value into the signed range of a width-bit word.
  function automatic logic signed [C_SAT_W-1:0] sat_clamp(
    input logic signed [C_SAT_W-1:0] value,
    input int unsigned               width
  );
    logic signed [C_SAT_W-1:0] max_v;
    logic signed [C_SAT_W-1:0] min_v;
    max_v = (C_SAT_W'(1) <<< (width - 1)) - C_SAT_W'(1);
    min_v = -max_v - C_SAT_W'(1);
    if (value > max_v)      return max_v;
    else if (value < min_v) return min_v;
    else                    return value;
  endfunction

endpackage

// File: rtl/poly_horner_eval_if.sv
// Sample-in / result-out streams plus the coefficient load port of poly_horner_eval.
interface poly_horner_eval_if
  import poly_horner_pkg::*;
#(
  parameter int G_DWIDTH = 24,
  parameter int G_CWIDTH = 32
);

  logic                       coef_wr_en;
  logic [C_ADDR_W-1:0]        coef_wr_addr;
  logic signed [G_CWIDTH-1:0] coef_wr_data;
  logic                       coef_wr_ready;

  logic signed [G_DWIDTH-1:0] din;
  logic                       din_valid;
  logic                       din_ready;

  logic signed [G_CWIDTH-1:0] dout;
  logic                       dout_valid;
  logic                       dout_ready;

  modport master (
    output coef_wr_en, coef_wr_addr, coef_wr_data, din, din_valid, dout_ready,
    input  coef_wr_ready, din_ready, dout, dout_valid
  );

  modport slave (
    input  coef_wr_en, coef_wr_addr, coef_wr_data, din, din_valid, dout_ready,
    output coef_wr_ready, din_ready, dout, dout_valid
  );

endinterface

// File: rtl/poly_horner_mac.sv
// One Horner step: sat((acc * x) >>> (G_DWIDTH-1) + coef), purely combinational.
// Define POLY_HORNER_ROUND_EN to round half up before the shift instead of flooring.
module poly_horner_mac
  import poly_horner_pkg::*;
#(
  parameter int G_DWIDTH = 24,
  parameter int G_CWIDTH = 32
) (
  input  logic signed [G_CWIDTH-1:0] acc,
  input  logic signed [G_DWIDTH-1:0] x,
  input  logic signed [G_CWIDTH-1:0] coef,
  output logic signed [G_CWIDTH-1:0] result
);

  localparam int PW = G_CWIDTH + G_DWIDTH;

`ifdef POLY_HORNER_ROUND_EN
  localparam logic signed [PW:0] ROUND_BIAS = (PW+1)'(1) <<< (G_DWIDTH - 2);
`else
  localparam logic signed [PW:0] ROUND_BIAS = '0;
`endif

  logic signed [PW-1:0] prod;
  logic signed [PW:0]   prod_adj;
  logic signed [PW:0]   shifted;
  logic signed [PW:0]   sum;

  // NOTE: combinational logic uses blocking '=' so each line sees the value computed just above it.
  always_comb begin
    prod     = PW'(acc) * PW'(x);
    prod_adj = (PW+1)'(prod) + ROUND_BIAS;
    shifted  = prod_adj >>> (G_DWIDTH - 1);
    sum      = shifted + (PW+1)'(coef);
    result   = G_CWIDTH'(sat_clamp(C_SAT_W'(sum), G_CWIDTH));
  end

endmodule

// File: rtl/poly_horner_eval.sv
// Horner-iteration polynomial evaluator with a writable coefficient bank and one shared MAC.
// Optional build macro POLY_HORNER_ROUND_EN selects round-half-up in the MAC step.
module poly_horner_eval
  import poly_horner_pkg::*;
#(
  parameter int G_POLY_ORDER = 5,
  parameter int G_DWIDTH     = 24,
  parameter int G_CWIDTH     = 32,
  parameter int G_CFRAC      = 16
) (
  input logic              clk,
  input logic              reset,
  input logic              enable,
  poly_horner_eval_if.slave bus
);

  if (G_POLY_ORDER > C_MAX_ORDER || G_CFRAC >= G_CWIDTH) begin : g_param_check
    $error("poly_horner_eval: illegal parameter combination");
  end

  localparam logic [C_ADDR_W-1:0] ADDR_N  = C_ADDR_W'(G_POLY_ORDER);
  localparam logic [C_ADDR_W-1:0] K_START =
    (G_POLY_ORDER > 0) ? C_ADDR_W'(G_POLY_ORDER - 1) : '0;

  state_t                     state;
  logic signed [G_CWIDTH-1:0] acc;
  logic signed [G_DWIDTH-1:0] x_reg;
  logic [C_ADDR_W-1:0]        k;
  logic signed [G_CWIDTH-1:0] coef [0:G_POLY_ORDER];

  logic                       active;
  logic                       in_idle;
  logic                       wr_hit;
  logic signed [G_CWIDTH-1:0] coef_k;
  logic signed [G_CWIDTH-1:0] coef_top;
  logic signed [G_CWIDTH-1:0] mac_result;

  // Outputs are gated by reset/enable so they are low in the very cycle either is applied.
  assign active            = enable && !reset;
  assign in_idle           = active && (state == SM_IDLE);
  assign bus.din_ready     = in_idle;
  assign bus.coef_wr_ready = in_idle;
  assign bus.dout_valid    = active && (state == SM_OUTPUT);
  assign bus.dout          = bus.dout_valid ? acc : '0;

  assign wr_hit = in_idle && bus.coef_wr_en && (bus.coef_wr_addr <= ADDR_N);

  // NOTE: every always_comb output gets a default first, otherwise an unmatched path infers a latch.
  always_comb begin
    coef_k = '0;
    for (int i = 0; i <= G_POLY_ORDER; i++) begin
      if (k == C_ADDR_W'(i)) coef_k = coef[i];
    end
  end

  // A write landing in the accepting cycle must already be visible to this evaluation.
  assign coef_top = (wr_hit && bus.coef_wr_addr == ADDR_N) ? bus.coef_wr_data
                                                             : coef[G_POLY_ORDER];

  poly_horner_mac #(
    .G_DWIDTH (G_DWIDTH),
    .G_CWIDTH (G_CWIDTH)
  ) u_mac (
    .acc    (acc),
    .x      (x_reg),
    .coef   (coef_k),
    .result (mac_result)
  );

  // NOTE: the coefficient bank is a register file with an explicit reset; enable=0 must keep it, so
  // it lives in its own block keyed on reset only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= G_POLY_ORDER; i++) coef[i] <= '0;
    end else if (wr_hit) begin
      for (int i = 0; i <= G_POLY_ORDER; i++) begin
        if (bus.coef_wr_addr == C_ADDR_W'(i)) coef[i] <= bus.coef_wr_data;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking '<=' so all registers switch together.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state <= SM_IDLE;
      acc   <= '0;
      x_reg <= '0;
      k     <= '0;
    end else begin
      case (state)
        SM_IDLE: begin
          if (bus.din_valid) begin
            x_reg <= bus.din;
            acc   <= coef_top;
            k     <= K_START;
            state <= (G_POLY_ORDER == 0) ? SM_OUTPUT : SM_MAC;
          end
        end
        SM_MAC: begin
          acc <= mac_result;
          if (k == '0) state <= SM_OUTPUT;
          else         k     <= k - 1'b1;
        end
        SM_OUTPUT: begin
          if (bus.dout_ready) state <= SM_IDLE;
        end
        default: state <= SM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_horner_eval.sv
// Directed bench for poly_horner_eval at N=2, DW=16, CW=24, CFRAC=16.
module tb_poly_horner_eval;

  localparam int N     = 2;
  localparam int DW    = 16;
  localparam int CW    = 24;
  localparam int CFRAC = 16;

  logic clk = 1'b0;
  logic reset;
  logic enable;

  poly_horner_eval_if #(.G_DWIDTH(DW), .G_CWIDTH(CW)) bus ();

  poly_horner_eval #(
    .G_POLY_ORDER (N),
    .G_DWIDTH     (DW),
    .G_CWIDTH     (CW),
    .G_CFRAC      (CFRAC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct {
    logic [CW-1:0] c0, c1, c2;
    logic [DW-1:0] x;
    logic [CW-1:0] y_trunc, y_round;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [CW-1:0] pick(input vec_t v);
`ifdef POLY_HORNER_ROUND_EN
    return v.y_round;
`else
    return v.y_trunc;
`endif
  endfunction

  task automatic write_coef(input logic [3:0] addr, input logic [CW-1:0] data);
    bus.coef_wr_en   = 1'b1;
    bus.coef_wr_addr = addr;
    bus.coef_wr_data = data;
    tick();
    bus.coef_wr_en   = 1'b0;
  endtask

  task automatic load3(input logic [CW-1:0] c0, input logic [CW-1:0] c1, input logic [CW-1:0] c2);
    write_coef(4'd0, c0);
    write_coef(4'd1, c1);
    write_coef(4'd2, c2);
  endtask

  // Accept one sample, wait (bounded) for the result, return it and the cycles after accept.
  task automatic run_eval(input logic [DW-1:0] x, output logic [CW-1:0] y, output int lat);
    bus.din        = x;
    bus.din_valid  = 1'b1;
    bus.dout_ready = 1'b0;
    tick();
    bus.din_valid  = 1'b0;
    lat = 0;
    while (!bus.dout_valid && lat < 50) begin
      tick();
      lat++;
    end
    y = bus.dout;
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] y;
    logic [CW-1:0] y0;
    int            lat;
    int            bad;
    int            pulses;

    //              c0         c1         c2         x         trunc      round
    vecs[0] = '{24'h008000, 24'h010000, 24'h000000, 16'h4000, 24'h010000, 24'h010000};
    vecs[1] = '{24'h000000, 24'h000000, 24'h010000, 16'hC000, 24'h004000, 24'h004000};
    vecs[2] = '{24'h7FFFFF, 24'h010000, 24'h000000, 16'h7FFF, 24'h7FFFFF, 24'h7FFFFF};
    vecs[3] = '{24'h800000, 24'h010000, 24'h000000, 16'h8000, 24'h800000, 24'h800000};
    vecs[4] = '{24'h000000, 24'h000001, 24'h000000, 16'h0001, 24'h000000, 24'h000000};
    vecs[5] = '{24'h000000, 24'h000001, 24'h000000, 16'h4000, 24'h000000, 24'h000001};
    vecs[6] = '{24'h000000, 24'h000003, 24'h000000, 16'hC000, 24'hFFFFFE, 24'hFFFFFF};
    vecs[7] = '{24'h010000, 24'h020000, 24'h010000, 16'h4000, 24'h024000, 24'h024000};

    reset            = 1'b1;
    enable           = 1'b1;
    bus.coef_wr_en   = 1'b0;
    bus.coef_wr_addr = '0;
    bus.coef_wr_data = '0;
    bus.din          = '0;
    bus.din_valid    = 1'b0;
    bus.dout_ready   = 1'b0;

    tick();
    check("rst_din_ready", bus.din_ready, 0);
    check("rst_dout_valid", bus.dout_valid, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_coef_wr_ready", bus.coef_wr_ready, 0);
    reset = 1'b0;
    tick();
    check("idle_din_ready", bus.din_ready, 1);

    for (int i = 0; i < 8; i++) begin
      load3(vecs[i].c0, vecs[i].c1, vecs[i].c2);
      run_eval(vecs[i].x, y, lat);
      check($sformatf("vec%0d_dout", i), y, pick(vecs[i]));
      check($sformatf("vec%0d_latency", i), lat, N);
    end

    // Throughput with both handshakes held high: one result per N+2 cycles.
    load3(24'h008000, 24'h010000, 24'h000000);
    bus.din = 16'h4000;
    bus.din_valid  = 1'b1;
    bus.dout_ready = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.dout_valid) pulses++;
    end
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b0;
    tick();
    check("throughput_pulses", pulses, 3);

    // Backpressure: result held, no accept, coefficient write ignored.
    bus.din = 16'h4000;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    lat = 0;
    while (!bus.dout_valid && lat < 50) begin
      tick();
      lat++;
    end
    y0  = bus.dout;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        bus.coef_wr_en = 1'b1; bus.coef_wr_addr = 4'd0; bus.coef_wr_data = 24'h7FFFFF;
      end
      tick();
      bus.coef_wr_en = 1'b0;
      if (bus.dout !== y0 || !bus.dout_valid || bus.din_ready || bus.coef_wr_ready) bad++;
    end
    check("bp_value", y0, 24'h010000);
    check("bp_hold_violations", bad, 0);
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    run_eval(16'h4000, y, lat);
    check("bp_write_ignored", y, 24'h010000);

    // Out-of-range addresses are dropped.
    write_coef(4'd3, 24'h7FFFFF);
    write_coef(4'd4, 24'h7FFFFF);
    run_eval(16'h4000, y, lat);
    check("addr_over_n_ignored", y, 24'h010000);

    // Write to c[N] in the accepting cycle is used by that evaluation: 0.5 + 0.5 + 0.25.
    bus.coef_wr_en = 1'b1; bus.coef_wr_addr = 4'd2; bus.coef_wr_data = 24'h010000;
    bus.din = 16'h4000; bus.din_valid = 1'b1;
    tick();
    bus.coef_wr_en = 1'b0; bus.din_valid = 1'b0;
    lat = 0;
    while (!bus.dout_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("same_cycle_write", bus.dout, 24'h014000);
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;

    // Reset in the middle of SM_MAC aborts and clears the bank.
    bus.din = 16'h4000; bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("midrst_dout_valid", bus.dout_valid, 0);
    check("midrst_din_ready", bus.din_ready, 0);
    reset = 1'b0;
    tick();
    check("postrst_din_ready", bus.din_ready, 1);
    check("postrst_dout_valid", bus.dout_valid, 0);
    run_eval(16'h4000, y, lat);
    check("postrst_coefs_zero", y, 24'h000000);

    // Dropping enable mid-evaluation aborts but keeps coefficients.
    load3(24'h008000, 24'h010000, 24'h000000);
    bus.din = 16'h4000; bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    enable = 1'b0;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.dout_valid || bus.din_ready || bus.coef_wr_ready) bad++;
    end
    check("disabled_outputs_low", bad, 0);
    enable = 1'b1;
    tick();
    check("reenable_dout_valid", bus.dout_valid, 0);
    check("reenable_din_ready", bus.din_ready, 1);
    run_eval(16'h4000, y, lat);
    check("enable_coefs_kept", y, 24'h010000);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
